// File: rtl/gtp_link_pkg.sv
// Shared types and constants for the GTP receive link.
package gtp_link_pkg;

  // Word-aligner FSM states.
  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    SLIDE,
    WAIT,
    CHECK,
    LOCKED
  } align_state_t;

  // Default comma/marker word the aligner hunts for.
  localparam logic [15:0] ALIGN_WORD_DEFAULT = 16'hBC50;

  // The GTP ignores an rxslide that arrives sooner than this many RXUSRCLK2
  // cycles after the previous one.
  localparam int unsigned SLIDE_WAIT_MIN = 32;

endpackage

// File: rtl/gtp_rx_slide_aligner.sv
// Receive word aligner: pulses rxslide until the periodic marker lands on the
// word boundary, confirms lock over several marker periods, then forwards
// data with a valid flag and drops back to search when markers go missing.
//
// Handshake: there is no backpressure. data_out/data_valid form a
// valid-only stream (a word is consumed in every cycle data_valid is high);
// rxslide is a one-cycle request with no acknowledge, and the transceiver is
// given at least SLIDE_WAIT cycles to act on it before another is issued.
module gtp_rx_slide_aligner
  import gtp_link_pkg::*;
#(
  parameter int unsigned       DATA_W     = 16,
  parameter logic [DATA_W-1:0] ALIGN_WORD = DATA_W'(ALIGN_WORD_DEFAULT),
  parameter int unsigned       SEARCH_WIN = 256,
  parameter int unsigned       SLIDE_WAIT = 32,
  parameter int unsigned       LOCK_CNT   = 4,
  parameter int unsigned       LOSS_CNT   = 3,
  parameter int unsigned       MAX_SLIDES = 20
) (
  input  logic              rx_user_clk2,
  input  logic              soft_reset,
  input  logic              rx_reset_done,
  input  logic [DATA_W-1:0] rxdata,
  output logic              rxslide,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              aligned,
  output logic              align_lost,
  output logic              slide_wrap,
  output logic [4:0]        slide_cnt,
  output align_state_t      dbg_state
);

  // Never wait less than the transceiver minimum, whatever the parameter says.
  localparam int unsigned WAIT_CYC = (SLIDE_WAIT < SLIDE_WAIT_MIN) ? SLIDE_WAIT_MIN : SLIDE_WAIT;
  localparam int unsigned WIN_W    = $clog2(SEARCH_WIN + 1);
  localparam int unsigned WAIT_W   = $clog2(WAIT_CYC + 1);
  localparam int unsigned EVT_MAX  = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int unsigned EVT_W    = $clog2(EVT_MAX + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(SEARCH_WIN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_CYC - 1);
  localparam logic [EVT_W-1:0]  LOCK_LAST  = EVT_W'(LOCK_CNT - 1);
  localparam logic [EVT_W-1:0]  LOSS_LAST  = EVT_W'(LOSS_CNT - 1);
  localparam logic [4:0]        SLIDE_LAST = 5'(MAX_SLIDES - 1);

  logic [1:0]        r_rst_pipe;
  logic              w_rst;

  align_state_t      r_state;
  align_state_t      w_state_nxt;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [WIN_W-1:0]  w_win_nxt;
  // Shared good/miss counter: counts markers in CHECK, missed windows in LOCKED.
  logic [EVT_W-1:0]  r_evt_cnt;
  logic [EVT_W-1:0]  w_evt_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [4:0]        r_slide_cnt;
  logic [4:0]        w_slide_cnt_nxt;
  logic              w_slide_wrap_nxt;
  logic              w_align_lost_nxt;

  logic              r_rxslide;
  logic              r_slide_wrap;
  logic              r_align_lost;
  logic              r_aligned;
  logic              r_data_valid;
  logic [DATA_W-1:0] r_data_out;

  logic              w_match;
  logic              w_win_expire;

  assign w_rst        = r_rst_pipe[1];
  assign w_match      = (rxdata == ALIGN_WORD);
  assign w_win_expire = (r_win_cnt == WIN_LAST);

  assign rxslide    = r_rxslide;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign aligned    = r_aligned;
  assign align_lost = r_align_lost;
  assign slide_wrap = r_slide_wrap;
  assign slide_cnt  = r_slide_cnt;
  assign dbg_state  = r_state;

  // Reset synchronizer: assert immediately, release two clocks later.
  always_ff @(posedge rx_user_clk2 or posedge soft_reset) begin
    if (soft_reset) r_rst_pipe <= 2'b11;
    else            r_rst_pipe <= {r_rst_pipe[0], 1'b0};
  end

  // Next-state and counter updates; match beats a simultaneous window expiry.
  always_comb begin
    w_state_nxt      = r_state;
    w_win_nxt        = r_win_cnt;
    w_evt_nxt        = r_evt_cnt;
    w_wait_nxt       = r_wait_cnt;
    w_slide_cnt_nxt  = r_slide_cnt;
    w_slide_wrap_nxt = 1'b0;
    w_align_lost_nxt = 1'b0;

    if (!rx_reset_done) begin
      // Slide position survives a transceiver reset; everything else restarts.
      w_state_nxt = IDLE;
      w_win_nxt   = '0;
      w_evt_nxt   = '0;
      w_wait_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SEARCH;
          w_win_nxt   = '0;
        end
        SEARCH: begin
          if (w_match) begin
            w_state_nxt = CHECK;
            w_evt_nxt   = EVT_W'(1);
            w_win_nxt   = '0;
          end else if (w_win_expire) begin
            w_state_nxt = SLIDE;
            w_win_nxt   = '0;
          end else begin
            w_win_nxt = r_win_cnt + WIN_W'(1);
          end
        end
        SLIDE: begin
          w_state_nxt = WAIT;
          w_wait_nxt  = '0;
        end
        WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = SEARCH;
            w_win_nxt   = '0;
            w_wait_nxt  = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
        CHECK: begin
          if (w_match) begin
            w_win_nxt = '0;
            if (r_evt_cnt == LOCK_LAST) begin
              w_state_nxt = LOCKED;
              w_evt_nxt   = '0;
            end else begin
              w_evt_nxt = r_evt_cnt + EVT_W'(1);
            end
          end else if (w_win_expire) begin
            w_state_nxt = SLIDE;
            w_evt_nxt   = '0;
            w_win_nxt   = '0;
          end else begin
            w_win_nxt = r_win_cnt + WIN_W'(1);
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_evt_nxt = '0;
            w_win_nxt = '0;
          end else if (w_win_expire) begin
            w_win_nxt = '0;
            if (r_evt_cnt == LOSS_LAST) begin
              w_state_nxt      = SEARCH;
              w_evt_nxt        = '0;
              w_align_lost_nxt = 1'b1;
            end else begin
              w_evt_nxt = r_evt_cnt + EVT_W'(1);
            end
          end else begin
            w_win_nxt = r_win_cnt + WIN_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_win_nxt   = '0;
          w_evt_nxt   = '0;
          w_wait_nxt  = '0;
        end
      endcase
    end

    // The slide position advances together with the rxslide pulse.
    if (w_state_nxt == SLIDE) begin
      if (r_slide_cnt == SLIDE_LAST) begin
        w_slide_cnt_nxt  = '0;
        w_slide_wrap_nxt = 1'b1;
      end else begin
        w_slide_cnt_nxt = r_slide_cnt + 5'd1;
      end
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge rx_user_clk2 or posedge w_rst) begin
    if (w_rst) begin
      r_state      <= IDLE;
      r_win_cnt    <= '0;
      r_evt_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_slide_cnt  <= '0;
      r_rxslide    <= 1'b0;
      r_slide_wrap <= 1'b0;
      r_align_lost <= 1'b0;
      r_aligned    <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_win_cnt    <= w_win_nxt;
      r_evt_cnt    <= w_evt_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_slide_cnt  <= w_slide_cnt_nxt;
      r_rxslide    <= (w_state_nxt == SLIDE);
      r_slide_wrap <= w_slide_wrap_nxt;
      r_align_lost <= w_align_lost_nxt;
      r_aligned    <= (w_state_nxt == LOCKED);
      r_data_valid <= (w_state_nxt == LOCKED);
    end
  end

  // Data path: rxdata is registered every cycle regardless of alignment state.
  always_ff @(posedge rx_user_clk2 or posedge w_rst) begin
    if (w_rst) r_data_out <= '0;
    else       r_data_out <= rxdata;
  end

endmodule
